freq_sort_ctrl: RTL

Sequencer for the systolic top-N sorting chain (chain of compare/shift register cells, each holding a (symbol, count) pair).
- Accumulates a histogram of LENGTH input symbols.
- Clears the chain, then streams every (symbol, count) bin into the chain head one per cycle.
- Signals done once the chain holds the sorted result.
- Sits between the symbol source and the sorting chain; the chain's parallel outputs are read by the consumer after done.

---
 rtl/freq_sort_pkg.sv | 34 +++
 rtl/freq_sort_ctrl_sym_hist.sv | 69 ++++++
 rtl/freq_sort_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/freq_sort_pkg.sv
// Shared types and sizing helpers for the histogram / top-N sort sequencer.
//   state_e      : sequencer states
//   cnt_max()    : saturation value of a bin of a given width
//   acc_width()  : width of the accepted-symbol counter for a frame length
//   idx_width()  : width of the bin index (never below 1 bit)
package freq_sort_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StAccum,
        StScan,
        StSettle,
        StDone
    } state_e;

    function automatic int unsigned cnt_max(input int unsigned length_size);
        return (2 ** length_size) - 1;
    endfunction

    function automatic int unsigned acc_width(input int unsigned length);
        return (length + 1 > 2) ? $clog2(length + 1) : 1;
    endfunction

    function automatic int unsigned idx_width(input int unsigned data_num);
        return (data_num > 1) ? $clog2(data_num) : 1;
    endfunction

    // Sizing for the default configuration.
    localparam int unsigned CNT_MAX = cnt_max(6);
    localparam int unsigned ACC_W   = acc_width(64);
    localparam int unsigned IDX_W   = idx_width(16);

endpackage

// File: rtl/freq_sort_ctrl_sym_hist.sv
// Histogram bin store: DATA_NUM bins of LENGTH_SIZE bits each.
//   clk, rst     : clock, asynchronous active-high reset
//   clr_i        : synchronous clear of every bin
//   inc_i        : saturating increment of bin inc_sym_i (ignored if out of range)
//   inc_sym_i    : symbol to count
//   rd_idx_i     : combinational read index
//   rd_count_o   : bin value as it will be after this cycle's clear/increment
module sym_hist
    import freq_sort_pkg::*;
#(
    parameter int unsigned DATA_SIZE   = 4,
    parameter int unsigned DATA_NUM    = 16,
    parameter int unsigned LENGTH_SIZE = 6
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clr_i,
    input  logic                             inc_i,
    input  logic [DATA_SIZE-1:0]             inc_sym_i,
    input  logic [idx_width(DATA_NUM)-1:0]   rd_idx_i,
    output logic [LENGTH_SIZE-1:0]           rd_count_o
);

    localparam logic [LENGTH_SIZE-1:0] CntMax = LENGTH_SIZE'(cnt_max(LENGTH_SIZE));

    logic [LENGTH_SIZE-1:0] bins_q [DATA_NUM];
    logic [DATA_NUM-1:0]    hit;

    // One-hot increment enable; a saturated bin simply stops counting.
    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < DATA_NUM; i++) begin
            hit[i] = inc_i && (32'(inc_sym_i) == i) && (bins_q[i] != CntMax);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DATA_NUM; i++) begin
                bins_q[i] <= '0;
            end
        end else if (clr_i) begin
            for (int unsigned i = 0; i < DATA_NUM; i++) begin
                bins_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DATA_NUM; i++) begin
                if (hit[i]) begin
                    bins_q[i] <= bins_q[i] + 1'b1;
                end
            end
        end
    end

    // Forwarded read: lets the controller register bin 0 on the same cycle as
    // the final handshake, even if that handshake targets bin 0.
    always_comb begin
        rd_count_o = '0;
        for (int unsigned i = 0; i < DATA_NUM; i++) begin
            if (32'(rd_idx_i) == i) begin
                rd_count_o = hit[i] ? bins_q[i] + 1'b1 : bins_q[i];
            end
        end
        if (clr_i) begin
            rd_count_o = '0;
        end
    end

endmodule

// File: rtl/freq_sort_ctrl.sv
// Sequencer for a systolic top-N sorting chain. Accumulates a histogram of
// LENGTH symbols, clears the chain, streams every (symbol, count) bin into the
// chain head one per cycle, then pulses done.
//   clk, rst        : clock, asynchronous active-high reset
//   start_i         : begin a frame (sampled only when idle)
//   sym_valid_i     : input symbol valid
//   sym_data_i      : input symbol
//   sym_ready_o     : symbol accepted on sym_valid_i && sym_ready_o
//   chain_clr_o     : one-cycle pulse to the chain cells' reset
//   chain_valid_o   : chain In_Valid
//   chain_data_o    : chain Data (bin index)
//   chain_count_o   : chain InCountNum (bin count)
//   busy_o          : high whenever not idle
//   done_o          : one-cycle pulse, chain result valid until next start
module freq_sort_ctrl
    import freq_sort_pkg::*;
#(
    parameter int unsigned DATA_SIZE   = 4,
    parameter int unsigned DATA_NUM    = 16,
    parameter int unsigned LENGTH      = 64,
    parameter int unsigned LENGTH_SIZE = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   sym_valid_i,
    input  logic [DATA_SIZE-1:0]   sym_data_i,
    output logic                   sym_ready_o,
    output logic                   chain_clr_o,
    output logic                   chain_valid_o,
    output logic [DATA_SIZE-1:0]   chain_data_o,
    output logic [LENGTH_SIZE-1:0] chain_count_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int unsigned AccW = acc_width(LENGTH);
    localparam int unsigned IdxW = idx_width(DATA_NUM);

    localparam logic [AccW-1:0] AccLast = AccW'(LENGTH);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_NUM - 1);

    state_e                 state_q, state_d;
    logic [AccW-1:0]        acc_cnt_q, acc_cnt_d;
    logic [IdxW-1:0]        idx_q, idx_d;

    logic                   sym_ready_q, sym_ready_d;
    logic                   chain_clr_q, chain_clr_d;
    logic                   chain_valid_q, chain_valid_d;
    logic [DATA_SIZE-1:0]   chain_data_q, chain_data_d;
    logic [LENGTH_SIZE-1:0] chain_count_q, chain_count_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   hs;
    logic [LENGTH_SIZE-1:0] rd_count;

    assign hs = sym_valid_i && sym_ready_q;

    sym_hist #(
        .DATA_SIZE  (DATA_SIZE),
        .DATA_NUM   (DATA_NUM),
        .LENGTH_SIZE(LENGTH_SIZE)
    ) u_sym_hist (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (state_q == StClear),
        .inc_i     (hs),
        .inc_sym_i (sym_data_i),
        .rd_idx_i  (idx_d),
        .rd_count_o(rd_count)
    );

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        acc_cnt_d = acc_cnt_q;
        idx_d     = idx_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                acc_cnt_d = '0;
                state_d   = StAccum;
            end
            StAccum: begin
                if (hs) begin
                    acc_cnt_d = acc_cnt_q + 1'b1;
                    if (acc_cnt_q + 1'b1 == AccLast) begin
                        state_d = StScan;
                        idx_d   = '0;
                    end
                end
            end
            StScan: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == IdxLast) begin
                    state_d = StSettle;
                end
            end
            StSettle: state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so every port is a flop that
    // lines up with the state it belongs to.
    always_comb begin
        sym_ready_d   = (state_d == StAccum);
        chain_clr_d   = (state_d == StClear);
        chain_valid_d = (state_d == StScan);
        chain_data_d  = '0;
        chain_count_d = '0;
        if (chain_valid_d) begin
            chain_data_d  = DATA_SIZE'(idx_d);
            chain_count_d = rd_count;
        end
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            acc_cnt_q     <= '0;
            idx_q         <= '0;
            sym_ready_q   <= 1'b0;
            chain_clr_q   <= 1'b0;
            chain_valid_q <= 1'b0;
            chain_data_q  <= '0;
            chain_count_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_cnt_q     <= acc_cnt_d;
            idx_q         <= idx_d;
            sym_ready_q   <= sym_ready_d;
            chain_clr_q   <= chain_clr_d;
            chain_valid_q <= chain_valid_d;
            chain_data_q  <= chain_data_d;
            chain_count_q <= chain_count_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign sym_ready_o   = sym_ready_q;
    assign chain_clr_o   = chain_clr_q;
    assign chain_valid_o = chain_valid_q;
    assign chain_data_o  = chain_data_q;
    assign chain_count_o = chain_count_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule
